// File: rtl/clock_burst_monitor.sv
// clock_burst_monitor: measures edge count, first period, high time and jitter of clk_in bursts.
// Optional high-time counter enabled by defining CLKMON_DUTY_EN.
module clock_burst_monitor #(
  parameter int CNT_W = 16,
  parameter int PER_W = 8,
  parameter int TIMEOUT = 32
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] edge_count,
  output logic [PER_W-1:0] period,
  output logic [PER_W-1:0] high_cycles,
  output logic             jitter_err
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  localparam logic [PER_W-1:0] TO1 = PER_W'(TIMEOUT - 1);
  state_t state, next;
  logic s1, s2, d, rise;
  logic [2:0] vld;
  logic [CNT_W-1:0] cnt;
  logic [PER_W-1:0] tmr, tmr_inc, first_per, diff;
  logic jit, start;
  // vld suppresses a false edge while the pipeline refills after reset
  always_ff @(posedge fastclk or negedge reset)
    if (!reset) begin
      {s1, s2, d, rise} <= '0;
      vld <= '0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      d <= s2;
      vld <= {vld[1:0], 1'b1};
      rise <= vld[2] & s2 & ~d;
    end
  always_ff @(posedge fastclk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state == BURST ? ((!rise && tmr == TO1) ? DONE : BURST) : (rise ? BURST : IDLE);
    start = rise && state != BURST;
    tmr_inc = &tmr ? tmr : tmr + 1'b1;
    diff = tmr_inc > first_per ? tmr_inc - first_per : first_per - tmr_inc;
  end
  assign busy = state == BURST;
  assign burst_done = state == DONE;
  always_ff @(posedge fastclk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      tmr <= '0;
      first_per <= '0;
      jit <= 1'b0;
      edge_count <= '0;
      period <= '0;
      jitter_err <= 1'b0;
    end else begin
      if (start) begin
        cnt <= CNT_W'(1);
        tmr <= '0;
        first_per <= '0;
        jit <= 1'b0;
      end else if (state == BURST) begin
        tmr <= rise ? '0 : tmr_inc;
        if (rise) begin
          cnt <= &cnt ? cnt : cnt + 1'b1;
          if (cnt == CNT_W'(1)) first_per <= tmr_inc;
          else if (diff > PER_W'(1)) jit <= 1'b1;
        end
      end
      if (next == DONE) begin
        edge_count <= cnt;
        period <= cnt == CNT_W'(1) ? '0 : first_per;
        jitter_err <= jit;
      end
    end
`ifdef CLKMON_DUTY_EN
  logic fall, hdone;
  logic [PER_W-1:0] hcnt, hcnt_inc;
  assign hcnt_inc = &hcnt ? hcnt : hcnt + 1'b1;
  // hcnt freezes at the first falling edge; otherwise it keeps the running count
  always_ff @(posedge fastclk or negedge reset)
    if (!reset) begin
      fall <= 1'b0;
      hdone <= 1'b0;
      hcnt <= '0;
      high_cycles <= '0;
    end else begin
      fall <= vld[2] & ~s2 & d;
      if (start) begin
        hcnt <= '0;
        hdone <= 1'b0;
      end else if (state == BURST && !hdone) begin
        hcnt <= hcnt_inc;
        hdone <= fall;
      end
      if (next == DONE) high_cycles <= cnt == CNT_W'(1) ? '0 : hcnt;
    end
`else
  assign high_cycles = '0;
`endif
endmodule
